mshr_entry_ctrl: RTL and testbench

MSHR entry state tracker and allocator that sits around `pre_alloc_two`: it exports the free-entry vector that `pre_alloc_two` scans, and it consumes the pre-allocated index pair to admit up to two miss requests per cycle. It holds per-entry state (FREE/RSVD/BUSY) and the stored line address of each entry. It blocks requests whose line is already in flight, and it frees entries on refill-complete release.

---
 rtl/mshr_pkg.sv | 21 ++
 rtl/mshr_line_cam.sv | 23 ++
 rtl/mshr_entry_ctrl.sv | 140 ++++++++++++++
 tb/tb_mshr_entry_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mshr_pkg.sv
// mshr_pkg: shared entry types, width defaults and line helper for the MSHR entry controller
package mshr_pkg;
  localparam int MSHR_ENTRY_NUM    = 32;
  localparam int MSHR_ADDR_WIDTH   = 40;
  localparam int MSHR_OFFSET_WIDTH = 6;
  localparam int MSHR_TXN_WIDTH    = 8;
  localparam int MSHR_LINE_WIDTH   = MSHR_ADDR_WIDTH - MSHR_OFFSET_WIDTH;
  typedef enum logic [1:0] {
    FREE = 2'd0,
    RSVD = 2'd1,
    BUSY = 2'd2
  } mshr_state_e;
  typedef struct packed {
    mshr_state_e                state;
    logic [MSHR_LINE_WIDTH-1:0] line;
    logic [MSHR_TXN_WIDTH-1:0]  txn;
  } mshr_entry_t;
  function automatic logic [MSHR_LINE_WIDTH-1:0] line_of(input logic [MSHR_ADDR_WIDTH-1:0] addr);
    return MSHR_LINE_WIDTH'(addr >> MSHR_OFFSET_WIDTH);
  endfunction
endpackage

// File: rtl/mshr_line_cam.sv
// mshr_line_cam: flags whether either query line matches the stored line of any BUSY entry
module mshr_line_cam
  import mshr_pkg::*;
#(
  parameter int ENTRY_NUM  = MSHR_ENTRY_NUM,
  parameter int LINE_WIDTH = MSHR_LINE_WIDTH
) (
  input  logic [ENTRY_NUM-1:0]                 busy_i,
  input  logic [ENTRY_NUM-1:0][LINE_WIDTH-1:0] lines_i,
  input  logic [LINE_WIDTH-1:0]                q0_i,
  input  logic [LINE_WIDTH-1:0]                q1_i,
  output logic                                 conf0_o,
  output logic                                 conf1_o
);
  always_comb begin
    conf0_o = 1'b0;
    conf1_o = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      conf0_o = conf0_o | (busy_i[i] && lines_i[i] == q0_i);
      conf1_o = conf1_o | (busy_i[i] && lines_i[i] == q1_i);
    end
  end
endmodule

// File: rtl/mshr_entry_ctrl.sv
// mshr_entry_ctrl: MSHR entry state tracker; exports free entries, admits up to two misses
// per cycle into pre-allocated entries, blocks in-flight lines and frees on release.
module mshr_entry_ctrl
  import mshr_pkg::*;
#(
  parameter int ENTRY_NUM      = MSHR_ENTRY_NUM,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int ADDR_WIDTH     = MSHR_ADDR_WIDTH,
  parameter int OFFSET_WIDTH   = MSHR_OFFSET_WIDTH,
  parameter int TXN_WIDTH      = MSHR_TXN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [ENTRY_NUM-1:0]      v_free_vld,
  input  logic [ENTRY_NUM-1:0]      v_free_rdy,
  input  logic                      pa_vld_0,
  input  logic                      pa_vld_1,
  output logic                      pa_rdy_0,
  output logic                      pa_rdy_1,
  input  logic [ENTRY_ID_WIDTH-1:0] pa_idx_0,
  input  logic [ENTRY_ID_WIDTH-1:0] pa_idx_1,
  input  logic                      req0_vld,
  output logic                      req0_rdy,
  input  logic [ADDR_WIDTH-1:0]     req0_addr,
  input  logic [TXN_WIDTH-1:0]      req0_txn,
  input  logic                      req1_vld,
  output logic                      req1_rdy,
  input  logic [ADDR_WIDTH-1:0]     req1_addr,
  input  logic [TXN_WIDTH-1:0]      req1_txn,
  output logic                      alloc_vld_0,
  output logic [ENTRY_ID_WIDTH-1:0] alloc_idx_0,
  output logic [ADDR_WIDTH-1:0]     alloc_addr_0,
  output logic [TXN_WIDTH-1:0]      alloc_txn_0,
  output logic                      alloc_vld_1,
  output logic [ENTRY_ID_WIDTH-1:0] alloc_idx_1,
  output logic [ADDR_WIDTH-1:0]     alloc_addr_1,
  output logic [TXN_WIDTH-1:0]      alloc_txn_1,
  input  logic                      rel_vld,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_idx,
  output logic [ENTRY_ID_WIDTH:0]   busy_cnt,
  output logic                      err_rel
);
  localparam int LW = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int CW = ENTRY_ID_WIDTH + 1;
  mshr_state_e                  state_q [ENTRY_NUM];
  mshr_state_e                  state_d [ENTRY_NUM];
  logic [ENTRY_NUM-1:0][LW-1:0] line_q, line_d;
  logic [ENTRY_NUM-1:0]         busy;
  logic [LW-1:0]                line0, line1, first_line;
  logic                         conf0, conf1, fire0, fire1, pop, both, rel_ok;

  assign line0 = req0_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
  assign line1 = req1_addr[ADDR_WIDTH-1:OFFSET_WIDTH];

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      busy[i]       = state_q[i] == BUSY;
      v_free_vld[i] = state_q[i] == FREE;
    end
  end

  mshr_line_cam #(
    .ENTRY_NUM (ENTRY_NUM),
    .LINE_WIDTH(LW)
  ) u_cam (
    .busy_i (busy),
    .lines_i(line_q),
    .q0_i   (line0),
    .q1_i   (line1),
    .conf0_o(conf0),
    .conf1_o(conf1)
  );

  // req1 only goes when req0 is absent or also going, and never on req0's line
  assign req0_rdy   = !rst_n && pa_vld_0 && !conf0;
  assign req1_rdy   = !rst_n && pa_vld_0 && !conf1 && (!req0_vld || req0_rdy) && !(req0_vld && line0 == line1);
  assign fire0      = req0_vld && req0_rdy;
  assign fire1      = req1_vld && req1_rdy;
  assign pop        = fire0 || fire1;
  assign both       = fire0 && fire1;
  assign pa_rdy_0   = pop;
  assign pa_rdy_1   = pop;
  assign first_line = fire0 ? line0 : line1;
  assign rel_ok     = rel_vld && state_q[rel_idx] == BUSY;

  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      state_d[i] = state_q[i];
      line_d[i]  = line_q[i];
      if (state_q[i] == FREE && v_free_rdy[i]) state_d[i] = RSVD;
      if (state_q[i] == RSVD && pop && pa_idx_0 == ENTRY_ID_WIDTH'(i)) begin
        state_d[i] = BUSY;
        line_d[i]  = first_line;
      end
      if (state_q[i] == RSVD && pop && pa_vld_1 && pa_idx_1 == ENTRY_ID_WIDTH'(i)) begin
        state_d[i] = both ? BUSY : FREE;
        line_d[i]  = line1;
      end
      if (rel_ok && rel_idx == ENTRY_ID_WIDTH'(i)) state_d[i] = FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) state_q[i] <= FREE;
      line_q       <= '0;
      alloc_vld_0  <= 1'b0;
      alloc_idx_0  <= '0;
      alloc_addr_0 <= '0;
      alloc_txn_0  <= '0;
      alloc_vld_1  <= 1'b0;
      alloc_idx_1  <= '0;
      alloc_addr_1 <= '0;
      alloc_txn_1  <= '0;
      busy_cnt     <= '0;
      err_rel      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      alloc_vld_0 <= pop;
      alloc_vld_1 <= both;
      if (pop) begin
        alloc_idx_0  <= pa_idx_0;
        alloc_addr_0 <= fire0 ? req0_addr : req1_addr;
        alloc_txn_0  <= fire0 ? req0_txn : req1_txn;
      end
      if (both) begin
        alloc_idx_1  <= pa_idx_1;
        alloc_addr_1 <= req1_addr;
        alloc_txn_1  <= req1_txn;
      end
      busy_cnt <= busy_cnt + CW'(fire0) + CW'(fire1) - CW'(rel_ok);
      err_rel  <= err_rel || (rel_vld && !rel_ok);
    end
  end

  a_pa0_rsvd: assert property (@(posedge clk) disable iff (rst_n) pop |-> state_q[pa_idx_0] == RSVD);
  a_pa1_rsvd: assert property (@(posedge clk) disable iff (rst_n) (pop && pa_vld_1) |-> state_q[pa_idx_1] == RSVD);
  a_pa1_vld:  assert property (@(posedge clk) disable iff (rst_n) both |-> pa_vld_1);
endmodule

// File: tb/tb_mshr_entry_ctrl.sv
// tb_mshr_entry_ctrl: table-driven cycle vectors plus reset sequences for mshr_entry_ctrl
module tb_mshr_entry_ctrl;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] v_free_vld, v_free_rdy;
  logic        pa_vld_0, pa_vld_1, pa_rdy_0, pa_rdy_1;
  logic [4:0]  pa_idx_0, pa_idx_1;
  logic        req0_vld, req0_rdy, req1_vld, req1_rdy;
  logic [39:0] req0_addr, req1_addr;
  logic [7:0]  req0_txn, req1_txn;
  logic        alloc_vld_0, alloc_vld_1;
  logic [4:0]  alloc_idx_0, alloc_idx_1;
  logic [39:0] alloc_addr_0, alloc_addr_1;
  logic [7:0]  alloc_txn_0, alloc_txn_1;
  logic        rel_vld;
  logic [4:0]  rel_idx;
  logic [5:0]  busy_cnt;
  logic        err_rel;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  mshr_entry_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .v_free_vld(v_free_vld), .v_free_rdy(v_free_rdy),
    .pa_vld_0(pa_vld_0), .pa_vld_1(pa_vld_1), .pa_rdy_0(pa_rdy_0), .pa_rdy_1(pa_rdy_1),
    .pa_idx_0(pa_idx_0), .pa_idx_1(pa_idx_1),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_txn(req0_txn),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_txn(req1_txn),
    .alloc_vld_0(alloc_vld_0), .alloc_idx_0(alloc_idx_0), .alloc_addr_0(alloc_addr_0), .alloc_txn_0(alloc_txn_0),
    .alloc_vld_1(alloc_vld_1), .alloc_idx_1(alloc_idx_1), .alloc_addr_1(alloc_addr_1), .alloc_txn_1(alloc_txn_1),
    .rel_vld(rel_vld), .rel_idx(rel_idx), .busy_cnt(busy_cnt), .err_rel(err_rel)
  );

  typedef struct {
    logic [31:0] gnt;
    logic        pv;
    logic [4:0]  pi0, pi1;
    logic        r0v;
    logic [39:0] r0a;
    logic        r1v;
    logic [39:0] r1a;
    logic        relv;
    logic [4:0]  reli;
    logic        e_r0, e_r1, e_pop;
    logic [31:0] e_free;
    logic [5:0]  e_busy;
    logic        e_av0;
    logic [4:0]  e_ai0;
    logic        e_av1;
    logic [4:0]  e_ai1;
    logic [39:0] e_aa0;
    logic        e_err;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    v_free_rdy = '0; pa_vld_0 = 0; pa_vld_1 = 0; pa_idx_0 = '0; pa_idx_1 = '0;
    req0_vld = 0; req0_addr = '0; req0_txn = 8'hA0;
    req1_vld = 0; req1_addr = '0; req1_txn = 8'hB1;
    rel_vld = 0; rel_idx = '0;
  endtask

  task automatic apply(input vec_t v);
    v_free_rdy = v.gnt; pa_vld_0 = v.pv; pa_vld_1 = v.pv; pa_idx_0 = v.pi0; pa_idx_1 = v.pi1;
    req0_vld = v.r0v; req0_addr = v.r0a; req1_vld = v.r1v; req1_addr = v.r1a;
    rel_vld = v.relv; rel_idx = v.reli;
  endtask

  initial begin
    //          gnt      pv pi0 pi1 r0v r0a     r1v r1a     rlv rli  r0 r1 pop free            bsy av0 ai0 av1 ai1 aa0     err
    vt[0]  = '{'h3,     0, 0,  0,  0,  0,      0,  0,      0,  0,   0, 0, 0,  'hFFFF_FFFC,    0,  0,  0,  0,  0,  0,      0};
    vt[1]  = '{0,       1, 0,  1,  1,  'h1000, 1,  'h2000, 0,  0,   1, 1, 1,  'hFFFF_FFFC,    2,  1,  0,  1,  1,  'h1000, 0};
    vt[2]  = '{'h30,    0, 0,  0,  0,  0,      0,  0,      0,  0,   0, 0, 0,  'hFFFF_FFCC,    2,  0,  0,  0,  0,  0,      0};
    vt[3]  = '{0,       1, 4,  5,  0,  0,      1,  'h3000, 0,  0,   1, 1, 1,  'hFFFF_FFEC,    3,  1,  4,  0,  0,  'h3000, 0};
    vt[4]  = '{'hC,     0, 0,  0,  0,  0,      0,  0,      0,  0,   0, 0, 0,  'hFFFF_FFE0,    3,  0,  0,  0,  0,  0,      0};
    vt[5]  = '{0,       1, 2,  3,  1,  'h1000, 0,  0,      1,  0,   0, 0, 0,  'hFFFF_FFE1,    2,  0,  0,  0,  0,  0,      0};
    vt[6]  = '{0,       1, 2,  3,  1,  'h1000, 1,  'h1020, 0,  0,   1, 0, 1,  'hFFFF_FFE9,    3,  1,  2,  0,  0,  'h1000, 0};
    vt[7]  = '{'h9,     0, 0,  0,  0,  0,      1,  'h1020, 0,  0,   0, 0, 0,  'hFFFF_FFE0,    3,  0,  0,  0,  0,  0,      0};
    vt[8]  = '{0,       1, 0,  3,  0,  0,      1,  'h1020, 1,  2,   1, 0, 0,  'hFFFF_FFE4,    2,  0,  0,  0,  0,  0,      0};
    vt[9]  = '{0,       1, 0,  3,  0,  0,      1,  'h1020, 0,  0,   1, 1, 1,  'hFFFF_FFEC,    3,  1,  0,  0,  0,  'h1020, 0};
    vt[10] = '{0,       0, 0,  0,  0,  0,      0,  0,      1,  7,   0, 0, 0,  'hFFFF_FFEC,    3,  0,  0,  0,  0,  0,      1};
    vt[11] = '{0,       0, 0,  0,  0,  0,      0,  0,      1,  1,   0, 0, 0,  'hFFFF_FFEE,    2,  0,  0,  0,  0,  0,      1};
    vt[12] = '{'hC,     0, 0,  0,  0,  0,      0,  0,      1,  4,   0, 0, 0,  'hFFFF_FFF2,    1,  0,  0,  0,  0,  0,      1};
    vt[13] = '{0,       1, 2,  3,  1,  'h5000, 1,  'h6040, 1,  0,   1, 1, 1,  'hFFFF_FFF3,    2,  1,  2,  1,  3,  'h5000, 1};
    idle();
    rst_n = 1;
    pa_vld_0 = 1; pa_vld_1 = 1; pa_idx_1 = 5'd1;
    req0_vld = 1; req0_addr = 40'h7000; req1_vld = 1; req1_addr = 40'h8000;
    @(negedge clk);
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_req1_rdy", req1_rdy, 0);
    chk("rst_pa_rdy_0", pa_rdy_0, 0);
    chk("rst_pa_rdy_1", pa_rdy_1, 0);
    @(posedge clk); #1;
    chk("rst_v_free", v_free_vld, 32'hFFFF_FFFF);
    chk("rst_busy_cnt", busy_cnt, 0);
    chk("rst_err_rel", err_rel, 0);
    chk("rst_alloc_vld_0", alloc_vld_0, 0);
    chk("rst_alloc_vld_1", alloc_vld_1, 0);
    chk("rst_alloc_addr_0", alloc_addr_0, 0);
    idle();
    rst_n = 0;
    for (int i = 0; i < 14; i++) begin
      apply(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d_req0_rdy", i), req0_rdy, vt[i].e_r0);
      chk($sformatf("v%0d_req1_rdy", i), req1_rdy, vt[i].e_r1);
      chk($sformatf("v%0d_pa_rdy_0", i), pa_rdy_0, vt[i].e_pop);
      chk($sformatf("v%0d_pa_rdy_1", i), pa_rdy_1, vt[i].e_pop);
      @(posedge clk); #1;
      chk($sformatf("v%0d_v_free", i), v_free_vld, vt[i].e_free);
      chk($sformatf("v%0d_busy_cnt", i), busy_cnt, vt[i].e_busy);
      chk($sformatf("v%0d_alloc_vld_0", i), alloc_vld_0, vt[i].e_av0);
      chk($sformatf("v%0d_alloc_vld_1", i), alloc_vld_1, vt[i].e_av1);
      chk($sformatf("v%0d_err_rel", i), err_rel, vt[i].e_err);
      if (vt[i].e_av0) begin
        chk($sformatf("v%0d_alloc_idx_0", i), alloc_idx_0, vt[i].e_ai0);
        chk($sformatf("v%0d_alloc_addr_0", i), alloc_addr_0, vt[i].e_aa0);
      end
      if (vt[i].e_av1) chk($sformatf("v%0d_alloc_idx_1", i), alloc_idx_1, vt[i].e_ai1);
    end
    chk("pair_alloc_addr_1", alloc_addr_1, 40'h6040);
    chk("pair_alloc_txn_0", alloc_txn_0, 8'hA0);
    chk("pair_alloc_txn_1", alloc_txn_1, 8'hB1);
    idle();
    @(posedge clk); #1;
    chk("idle_alloc_vld_0", alloc_vld_0, 0);
    chk("idle_err_hold", err_rel, 1);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst2_err_rel", err_rel, 0);
    chk("rst2_busy_cnt", busy_cnt, 0);
    chk("rst2_v_free", v_free_vld, 32'hFFFF_FFFF);
    chk("rst2_alloc_idx_1", alloc_idx_1, 0);
    chk("rst2_alloc_addr_1", alloc_addr_1, 0);
    rst_n = 0;
    @(posedge clk); #1;
    chk("post_rst_err_rel", err_rel, 0);
    chk("post_rst_v_free", v_free_vld, 32'hFFFF_FFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
